// File: rtl/csa_pkg.sv
// Shared types and default widths for the carry-save accumulator.
package csa_pkg;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int WIDTH_DEF     = 8;
    localparam int ACC_WIDTH_DEF = 12;

endpackage

// File: rtl/csa_row.sv
// One row of 3:2 compressors: bitwise sum and majority of three words.
module csa_row #(
    parameter int W = 12
) (
    input  logic [W-1:0] s,
    input  logic [W-1:0] c,
    input  logic [W-1:0] x,
    output logic [W-1:0] sum,
    output logic [W-1:0] maj
);

    assign sum = s ^ c ^ x;
    assign maj = (s & c) | (s & x) | (c & x);

endmodule

// File: rtl/csa_accum_unit.sv
// Multi-operand accumulator in carry-save form with iterative resolve.
// Optional macro CSA_ACCUM_SATURATE_EN: saturate out_sum to all ones on overflow.
module csa_accum_unit
    import csa_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic                 out_ovf,
    output logic                 busy
);

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] s_q, s_d, c_q, c_d;
    logic                 ovf_q, ovf_d;
    logic [ACC_WIDTH-1:0] row_x, row_sum, row_maj;
    logic                 accept;

    // In RESOLVE the third row input is zero, so maj collapses to S&C.
    assign row_x  = (state_q == ACCUM) ? {{(ACC_WIDTH-WIDTH){1'b0}}, in_data} : '0;
    assign accept = in_valid && in_ready;

    csa_row #(.W(ACC_WIDTH)) u_row (
        .s   (s_q),
        .c   (c_q),
        .x   (row_x),
        .sum (row_sum),
        .maj (row_maj)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            s_q     <= '0;
            c_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        c_d     = c_q;
        ovf_d   = ovf_q;
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    s_d   = row_sum;
                    c_d   = row_maj << 1;
                    ovf_d = ovf_q | row_maj[ACC_WIDTH-1];
                    if (in_last) state_d = RESOLVE;
                end
            end
            RESOLVE: begin
                if (c_q == '0) begin
                    state_d = DONE;
                end else begin
                    s_d   = row_sum;
                    c_d   = row_maj << 1;
                    ovf_d = ovf_q | row_maj[ACC_WIDTH-1];
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = ACCUM;
                    s_d     = '0;
                    c_d     = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    assign in_ready  = (state_q == ACCUM) && !rst;
    assign out_valid = (state_q == DONE);
    assign out_ovf   = (state_q == DONE) && ovf_q;
    assign busy      = (state_q != ACCUM);

    always_comb begin
        out_sum = '0;
        if (state_q == DONE) begin
`ifdef CSA_ACCUM_SATURATE_EN
            out_sum = ovf_q ? '1 : s_q;
`else
            out_sum = s_q;
`endif
        end
    end

endmodule

// File: tb/tb_csa_accum_unit.sv
// Directed and randomized checks of csa_accum_unit against an integer-sum model.
module tb_csa_accum_unit;

    localparam int W  = 8;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_sum;
    logic          out_ovf;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] ops_q[$];

    always #5 clk = ~clk;

    csa_accum_unit #(.WIDTH(W), .ACC_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] model_sum(input int total);
`ifdef CSA_ACCUM_SATURATE_EN
        if (total > 4095) return 12'hFFF;
`endif
        return total[AW-1:0];
    endfunction

    // Feed ops_q as one group; returns the edge count from the last accept
    // (inclusive) until out_valid is seen.
    task automatic send_group(input string tag, output int lat, output int total);
        total = 0;
        foreach (ops_q[i]) begin
            check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_data  = ops_q[i];
            in_last  = (i == ops_q.size() - 1);
            total   += int'(ops_q[i]);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input int total, input int lat);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_latency_bound"}, 32'(lat <= 2 + AW), 32'd1);
        check({tag, "_out_sum"}, 32'(out_sum), 32'(model_sum(total)));
        check({tag, "_out_ovf"}, 32'(out_ovf), 32'(total > 4095));
        check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_released"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_again"}, 32'(in_ready), 32'd1);
    endtask

    task automatic check_idle(input string tag, input logic exp_ready);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_sum"}, 32'(out_sum), 32'd0);
        check({tag, "_out_ovf"}, 32'(out_ovf), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'(exp_ready));
    endtask

    initial begin
        int lat, total, n;
        logic [AW-1:0] held_sum;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset", 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_idle("post_reset", 1'b1);

        ops_q = '{8'h2A, 8'hB5};
        send_group("two_ops", lat, total);
        check_result("two_ops", total, lat);
        check("two_ops_sum_const", 32'(model_sum(total)), 32'h0DF);

        ops_q = '{8'h80};
        send_group("single", lat, total);
        check("single_latency", 32'(lat), 32'd2);
        check_result("single", total, lat);

        ops_q.delete();
        repeat (16) ops_q.push_back(8'hFF);
        send_group("sixteen_ff", lat, total);
        check_result("sixteen_ff", total, lat);

        ops_q.push_back(8'hFF);
        send_group("seventeen_ff", lat, total);
        check_result("seventeen_ff", total, lat);

        // Hold the result with out_ready low and watch it stay put.
        ops_q = '{8'h5C, 8'h77, 8'h31};
        send_group("stall", lat, total);
        held_sum = out_sum;
        check("stall_first_sum", 32'(held_sum), 32'(model_sum(total)));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_sum", 32'(out_sum), 32'(held_sum));
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        check_result("stall", total, lat);
        ops_q = '{8'h01};
        send_group("after_stall", lat, total);
        check_result("after_stall", total, lat);

        // Reset in the middle of RESOLVE drops the group.
        in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b0;
        @(negedge clk);
        in_data = 8'h01; in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        check("mid_resolve_busy", 32'(busy), 32'd1);
        check("mid_resolve_valid", 32'(out_valid), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_idle("abort_reset", 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check_idle("abort_quiet", 1'b1);
        end
        ops_q = '{8'h03};
        send_group("after_abort", lat, total);
        check_result("after_abort", total, lat);

        // Randomized groups, some biased toward large values to reach overflow.
        for (int g = 0; g < 24; g++) begin
            n = $urandom_range(1, 22);
            ops_q.delete();
            for (int i = 0; i < n; i++) begin
                if (g % 3 == 0) ops_q.push_back(8'($urandom_range(200, 255)));
                else            ops_q.push_back(8'($urandom_range(0, 255)));
            end
            send_group("rand", lat, total);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 4)) begin
                    @(negedge clk);
                    check("rand_hold_sum", 32'(out_sum), 32'(model_sum(total)));
                end
            end
            check_result("rand", total, lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/csa_accum_unit.md
# csa_accum_unit

Sequential multi-operand accumulator that sits directly upstream of the 8-bit carry-save adder datapath. Accepts a stream of unsigned operands over a valid/ready handshake and keeps the running total in redundant carry-save form, so each operand is absorbed in one cycle with no carry propagation. On the operand tagged `in_last`, it iteratively resolves the redundant pair into a binary sum and presents that sum downstream with an overflow flag.

## Interface
- `WIDTH`, 8: operand width.
- `ACC_WIDTH`, 12: accumulator width. Holds up to 16 full-scale operands without overflow.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operand present.
- `in_ready` output 1: block can accept an operand.
- `in_data` input WIDTH: unsigned operand, zero-extended to ACC_WIDTH.
- `in_last` input 1: final operand of the current group.
- `out_valid` output 1: resolved result available.
- `out_ready` input 1: downstream accepts the result.
- `out_sum` output ACC_WIDTH: resolved sum.
- `out_ovf` output 1: the true sum exceeded 2^ACC_WIDTH−1.
- `busy` output 1: high in RESOLVE or DONE.

## Operation
- State registers:
  - `S` and `C`, each ACC_WIDTH bits.
  - sticky `ovf`.
  - FSM with states ACCUM, RESOLVE, DONE.
- Invariant: the accumulated value equals S + C (mod 2^ACC_WIDTH). `ovf` records any 2^ACC_WIDTH carry that has been dropped.
- ACCUM:
  - `in_ready` = 1.
  - On accept (`in_valid && in_ready`), with X = zero-extended `in_data`:
    - S ← S^C^X
    - M = maj(S,C,X)
    - C ← M<<1
    - `ovf` ← `ovf` | M[ACC_WIDTH−1]
  - If `in_last` is set on the accept, go to RESOLVE.
- RESOLVE:
  - If C == 0, go to DONE with no register change.
  - Otherwise:
    - S ← S^C
    - C ← (S&C)<<1
    - `ovf` ← `ovf` | (S&C)[ACC_WIDTH−1]
  - Terminates in at most ACC_WIDTH iterations.
- DONE:
  - `out_valid` = 1, `out_sum` = S, `out_ovf` = `ovf`.
  - On `out_ready`, clear S, C and `ovf`, then go to ACCUM.
- `in_ready` is low in RESOLVE and DONE, and low while `rst` is high.
- `in_valid` without `in_last` only accumulates. There is no operand-count limit; overflow is detected purely by dropped carries.

## Timing
- Reset state, held from the first edge with `rst` high:
  - state ACCUM; S = C = 0; `ovf` = 0.
  - `out_valid` = 0, `out_sum` = 0, `out_ovf` = 0, `busy` = 0.
  - `in_ready` = 1 from the first cycle after `rst` falls.
- Throughput: one operand per cycle in ACCUM.
- Latency from the `in_last` accept edge to `out_valid`: 1 + k cycles, where k is the number of nonzero-C resolve iterations (0 ≤ k ≤ ACC_WIDTH).
- A `last` operand producing C = 0 gives `out_valid` two edges after the accept.
- `out_valid`, `out_sum` and `out_ovf` stay stable while `out_ready` is low.
- If `out_valid && out_ready`, ACCUM is entered the next cycle. No operand is accepted in the same cycle as the result handshake.
- `rst` asserted in any state, including mid-RESOLVE or DONE, aborts the group. All registers return to reset values on that edge, and no partial result is emitted.
- `in_last` on the first operand of a group is legal (single-operand group).

## Configuration
- `CSA_ACCUM_SATURATE_EN` defined: when `ovf` = 1, `out_sum` is forced to all ones (2^ACC_WIDTH−1) in DONE. `out_ovf` still reports overflow.
- Not defined: `out_sum` is the wrapped modulo-2^ACC_WIDTH sum.

## Structure
- The shared package `csa_pkg` holds:
  - the FSM state enum {ACCUM, RESOLVE, DONE};
  - default width constants WIDTH_DEF = 8 and ACC_WIDTH_DEF = 12.
- One sub-module, `csa_row`: a parameterised ACC_WIDTH 3:2 compressor (inputs s, c, x; outputs sum = s^c^x and maj).
  - ACCUM uses it with x = X.
  - RESOLVE reuses it with x = 0, so maj reduces to S&C.

## Test plan
- Operands 0x2A, then 0xB5 with `last` → `out_sum` = 0x0DF, `out_ovf` = 0.
- Single operand 0x80 with `last` → `out_sum` = 0x080, `out_valid` two cycles after accept, no resolve iterations.
- Sixteen × 0xFF, 16th with `last` → `out_sum` = 0xFF0, `out_ovf` = 0.
- Seventeen × 0xFF → `out_ovf` = 1; `out_sum` = 0x0EF without the macro, 0xFFF with `CSA_ACCUM_SATURATE_EN`.
- Result with `out_ready` held low 5 cycles → `out_valid`/`out_sum` stable, `in_ready` = 0; on release, the next group 0x01 with `last` yields 0x001.
- `rst` pulsed during RESOLVE after 0xFF, 0x01 (`last`) → no `out_valid`; all outputs zero; the next group 0x03 with `last` yields 0x003.
